// File: rtl/scie_fir_sequencer.sv
// scie_fir_sequencer: sequences coefficient loads, sample pushes and result reads into a SCIE FIR datapath.
module scie_fir_sequencer #(
  parameter int NTAPS = 5,
  parameter int W = 16,
  parameter int GAP = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       io_cfg_valid,
  output logic                       io_cfg_ready,
  input  logic [$clog2(NTAPS)-1:0]   io_cfg_idx,
  input  logic [W-1:0]               io_cfg_real,
  input  logic [W-1:0]               io_cfg_imag,
  input  logic                       io_in_valid,
  output logic                       io_in_ready,
  input  logic [W-1:0]               io_in_real,
  input  logic [W-1:0]               io_in_imag,
  output logic                       io_out_valid,
  input  logic                       io_out_ready,
  output logic [W-1:0]               io_out_real,
  output logic [W-1:0]               io_out_imag,
  output logic                       io_dp_valid,
  output logic [31:0]                io_dp_insn,
  output logic [W-1:0]               io_dp_rs1_real,
  output logic [W-1:0]               io_dp_rs1_imag,
  output logic [31:0]                io_dp_rs2,
  input  logic [W-1:0]               io_dp_rd_real,
  input  logic [W-1:0]               io_dp_rd_imag,
  output logic                       io_coef_ok,
  output logic                       io_busy
);
  localparam int GW = $clog2(GAP + 2);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PUSH, S_GAP, S_READ, S_CAPT} state_t;
  state_t state;
  logic [NTAPS-1:0] mask;
  logic [GW-1:0] cnt;
  assign io_coef_ok = &mask;
  assign io_busy = state != S_IDLE;
  assign io_cfg_ready = state == S_IDLE;
  // a pending cfg write always wins over a sample in the same cycle
  assign io_in_ready = state == S_IDLE && io_coef_ok && !io_out_valid && !io_cfg_valid;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      mask <= '0;
      cnt <= '0;
      io_out_valid <= 1'b0;
      io_out_real <= '0;
      io_out_imag <= '0;
      io_dp_valid <= 1'b0;
      io_dp_insn <= '0;
      io_dp_rs1_real <= '0;
      io_dp_rs1_imag <= '0;
      io_dp_rs2 <= '0;
    end else begin
      io_dp_valid <= 1'b0;
      io_dp_insn <= '0;
      if (io_out_valid && io_out_ready) begin
        io_out_valid <= 1'b0;
        io_out_real <= '0;
        io_out_imag <= '0;
      end
      case (state)
        S_IDLE:
          if (io_cfg_valid) begin
            if (int'(io_cfg_idx) < NTAPS) begin
              state <= S_LOAD;
              io_dp_valid <= 1'b1;
              io_dp_insn <= 32'd11;
              io_dp_rs1_real <= io_cfg_real;
              io_dp_rs1_imag <= io_cfg_imag;
              io_dp_rs2 <= 32'(io_cfg_idx);
              mask[io_cfg_idx] <= 1'b1;
            end
          end else if (io_in_ready && io_in_valid) begin
            state <= S_PUSH;
            io_dp_valid <= 1'b1;
            io_dp_insn <= 32'd43;
            io_dp_rs1_real <= io_in_real;
            io_dp_rs1_imag <= io_in_imag;
            io_dp_rs2 <= '0;
          end
        S_LOAD: state <= S_IDLE;
        S_PUSH: begin
          cnt <= '0;
          state <= GAP == 0 ? S_READ : S_GAP;
          io_dp_valid <= GAP == 0;
          io_dp_insn <= GAP == 0 ? 32'd91 : 32'd0;
        end
        S_GAP:
          if (cnt == GW'(GAP - 1)) begin
            state <= S_READ;
            io_dp_valid <= 1'b1;
            io_dp_insn <= 32'd91;
          end else cnt <= cnt + 1'b1;
        S_READ: state <= S_CAPT;
        S_CAPT: begin
          state <= S_IDLE;
          io_out_valid <= 1'b1;
          io_out_real <= io_dp_rd_real;
          io_out_imag <= io_dp_rd_imag;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/scie_fir_sequencer.md
SCIE_FIR_SEQUENCER -- requirements
Module: scie_fir_sequencer

Interface
REQ-001 Parameter NTAPS, default 5: number of complex FIR taps in the attached SCIEPipelined datapath.
REQ-002 Parameter W, default 16: signed width of each real/imag component.
REQ-003 Parameter GAP, default 1: idle datapath cycles between push and read.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 io_cfg_valid / io_cfg_ready  input / output  1 / 1  coefficient-write handshake.
REQ-007 io_cfg_idx  input  clog2(NTAPS)  tap index.
REQ-008 io_cfg_real, io_cfg_imag  input  W each  signed coefficient.
REQ-009 io_in_valid / io_in_ready  input / output  1 / 1  sample handshake.
REQ-010 io_in_real, io_in_imag  input  W each  signed sample.
REQ-011 io_out_valid / io_out_ready  output / input  1 / 1  result handshake.
REQ-012 io_out_real, io_out_imag  output  W each  signed filter result.
REQ-013 io_dp_valid, io_dp_insn[31:0], io_dp_rs1_real[W], io_dp_rs1_imag[W], io_dp_rs2[31:0]  output  drive the datapath's io_valid, io_insn, io_rs1_*, io_rs2.
REQ-014 io_dp_rd_real, io_dp_rd_imag  input  W each  datapath result.
REQ-015 io_coef_ok  output  1  all NTAPS taps written since reset.
REQ-016 io_busy  output  1  FSM not in IDLE.

Function
REQ-017 Opcodes: load-coef = 11, push-sample = 43, read-result = 91.
REQ-018 FSM states: IDLE, LOAD, PUSH, GAP, READ, CAPT; all datapath drive outputs are registered.
REQ-019 io_cfg_ready = 1 only in IDLE; io_in_ready = 1 only in IDLE with io_coef_ok = 1 and io_out_valid = 0.
REQ-020 IDLE with both handshakes offered: cfg wins; io_in_ready is forced to 0 in that cycle.
REQ-021 cfg accepted with idx < NTAPS -> LOAD for 1 cycle: dp_valid = 1, insn = 11, rs1 = cfg value, rs2 = idx (zero-extended); set mask bit idx; return to IDLE.
REQ-022 cfg accepted with idx >= NTAPS: handshake completes, no datapath issue, mask unchanged, FSM stays IDLE.
REQ-023 Sample accepted in cycle k -> PUSH in k+1 (dp_valid = 1, insn = 43, rs1 = sample, rs2 = 0).
REQ-024 Then GAP for cycles k+2..k+1+GAP with dp_valid = 0; READ in k+2+GAP (dp_valid = 1, insn = 91).
REQ-025 CAPT in k+3+GAP: io_dp_rd_* is sampled at the end of that cycle into the output register; io_out_valid = 1 from k+4+GAP; FSM returns to IDLE.
REQ-026 io_out_valid and data hold stable until io_out_ready = 1; they clear on the handshake edge.
REQ-027 cfg writes are allowed while a result is held; the held result is not altered.
REQ-028 Whenever dp_valid = 0: insn = 0; rs1/rs2 hold their last values.
REQ-029 Results are passed through bit-exact (no rounding or saturation); width W.
REQ-030 A sample is never issued to the datapath unless io_coef_ok = 1.

Reset
REQ-031 Reset asserted: state = IDLE; mask = 0; io_coef_ok = 0; io_out_valid = 0; io_out_* = 0; io_dp_valid = 0; io_dp_insn/rs1/rs2 = 0; io_busy = 0.
REQ-032 Reset asserted mid-sequence (any state): the in-flight sample is abandoned, no io_out_valid results from it, and coefficients must be reloaded.
REQ-033 The first handshake can be accepted on the first rising edge after reset deasserts.

Verification (sequencer bench with SCIEPipelined attached)
REQ-034 Load taps 0..4 = (30,-49), (-29,-2), (-19,-1), (-22,-17), (-21,35) -> five LOAD cycles with insn 11, rs2 = 0..4; io_coef_ok = 1 after the fifth.
REQ-035 Then sample (33,-36) -> dp insn sequence 43, 0, 91 on consecutive cycles; io_out = (-774,-2697) with io_out_valid at k+5; next sample (4,-4) -> (-1105,662).
REQ-036 Sample offered before all taps are loaded -> io_in_ready = 0 and no dp_valid for any number of cycles; cfg idx = 7 -> accepted, no dp_valid, io_coef_ok unchanged.
REQ-037 io_out_ready held 0 for 10 cycles after a result -> io_out_valid and data stable; io_in_ready = 0; after release, the next sample is accepted on the following IDLE cycle.
REQ-038 Reset pulsed during the READ cycle -> all outputs equal the REQ-031 values; io_out_valid never rises; a sample is refused until five taps are reloaded.
REQ-039 cfg_valid and in_valid both high in IDLE -> cfg is taken first (LOAD), and the sample is accepted in the next IDLE cycle.
